// File: rtl/exec_decode_unit_pkg.sv
// Shared definitions for the RV32I execute/decode slice.
// Contents: opcode constants, ALU operation-class encodings (alu_op) and
// the decoded ALU operation codes (alu_control).
package exec_decode_unit_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

endpackage

// File: rtl/exec_decode_unit_alu32_core.sv
// alu32_core: combinational 32-bit integer ALU.
// Ports:
//   operand1, operand2 : XLEN-bit operands
//   alu_control        : decoded operation (alu_ctrl_e encoding)
//   result             : operation result (0 for undefined codes)
//   zero               : result == 0
module alu32_core
  import exec_decode_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] op1_s;
  logic signed [XLEN-1:0] op2_s;
  logic        [4:0]      shamt;

  assign op1_s = operand1;
  assign op2_s = operand2;
  assign shamt = operand2[4:0];

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_ADD:  result = operand1 + operand2;
      ALU_SUB:  result = operand1 - operand2;
      ALU_AND:  result = operand1 & operand2;
      ALU_OR:   result = operand1 | operand2;
      ALU_XOR:  result = operand1 ^ operand2;
      ALU_SLL:  result = operand1 << shamt;
      ALU_SRL:  result = operand1 >> shamt;
      ALU_SRA:  result = $unsigned(op1_s >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (operand1 < operand2)};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/exec_decode_unit.sv
// exec_decode_unit: main decoder, ALU-control decoder and 32-bit ALU for a
// single-cycle RV32I core, with one registered copy of the ALU outputs.
// Ports:
//   clk, rst (sync, active-low)      : clock / reset of result_q, zero_q only
//   instruction, pc, rs1_data,
//   rs2_data, imm                    : decode and operand inputs
//   alu_src .. jump                  : datapath control strobes
//   alu_control                      : decoded ALU operation
//   alu_result, zero, take_branch    : combinational ALU outputs
//   result_q, zero_q                 : alu_result / zero registered
module exec_decode_unit
  import exec_decode_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            alu_src,
  output logic [1:0]      alu_op,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            jump,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            take_branch,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;
  logic       unused_bits;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign f7b5        = instruction[30];
  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  alu_op_e         op_class;
  alu_ctrl_e       ctrl;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            branch_cond;

  always_comb begin
    alu_src    = 1'b0;
    op_class   = ALUOP_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_write = 1'b1;
        op_class  = ALUOP_RTYPE;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        op_class  = ALUOP_ITYPE;
      end
      OP_LOAD: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      OP_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        branch   = 1'b1;
        op_class = ALUOP_BRANCH;
      end
      OP_JAL: begin
        jump      = 1'b1;
        reg_write = 1'b1;
      end
      OP_JALR: begin
        jump      = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_op = op_class;

  // Branch compares reuse SUB for equality and SLT/SLTU for ordering; the
  // branch condition then inspects zero or bit 0 of the result.
  always_comb begin
    ctrl = ALU_ADD;
    case (op_class)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b100, 3'b101: ctrl = ALU_SLT;
          3'b110, 3'b111: ctrl = ALU_SLTU;
          default:        ctrl = ALU_SUB;
        endcase
      end
      default: begin
        case (funct3)
          // ADDI has no SUB form, so bit 30 only matters for R-type.
          3'b000:  ctrl = (op_class == ALUOP_RTYPE && f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  assign alu_control = ctrl;

  always_comb begin
    case (opcode)
      OP_AUIPC: operand1 = pc;
      OP_LUI:   operand1 = '0;
      default:  operand1 = rs1_data;
    endcase
  end

  assign operand2 = alu_src ? imm : rs2_data;

  alu32_core #(.XLEN(XLEN)) u_alu (
    .operand1    (operand1),
    .operand2    (operand2),
    .alu_control (alu_control),
    .result      (alu_result),
    .zero        (zero)
  );

  always_comb begin
    case (funct3)
      3'b000:         branch_cond = zero;
      3'b001:         branch_cond = ~zero;
      3'b100, 3'b110: branch_cond = alu_result[0];
      3'b101, 3'b111: branch_cond = ~alu_result[0];
      default:        branch_cond = 1'b0;
    endcase
  end

  assign take_branch = branch & branch_cond;

  // Register stage: trace copy of the ALU outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= alu_result;
      zero_q   <= zero;
    end
  end

endmodule

// File: tb/tb_exec_decode_unit.sv
module tb_exec_decode_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction, pc, rs1_data, rs2_data, imm;
  logic        alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump;
  logic [1:0]  alu_op;
  logic [3:0]  alu_control;
  logic [31:0] alu_result, result_q;
  logic        zero, take_branch, zero_q;

  int tests_run = 0;
  int tests_failed = 0;

  // strobe vector: {alu_src, alu_op[1:0], mem_to_reg, reg_write, mem_read, mem_write, branch, jump}
  localparam logic [8:0] S_R    = 9'b010010000;
  localparam logic [8:0] S_I    = 9'b111010000;
  localparam logic [8:0] S_LD   = 9'b100111000;
  localparam logic [8:0] S_ST   = 9'b100000100;
  localparam logic [8:0] S_BR   = 9'b001000010;
  localparam logic [8:0] S_U    = 9'b100010000;
  localparam logic [8:0] S_JAL  = 9'b000010001;
  localparam logic [8:0] S_JALR = 9'b100010001;
  localparam logic [8:0] S_NONE = 9'b000000000;

  typedef struct {
    string       tag;
    logic [8:0]  strobes;
    logic [3:0]  ctrl;
    logic [31:0] result;
    logic        zero;
    logic        take;
  } comb_exp_t;

  typedef struct {
    string       tag;
    logic [31:0] result;
    logic        zero;
  } reg_exp_t;

  comb_exp_t comb_q[$];
  reg_exp_t  reg_q[$];

  exec_decode_unit #(.XLEN(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .alu_src     (alu_src),
    .alu_op      (alu_op),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .branch      (branch),
    .jump        (jump),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .zero        (zero),
    .take_branch (take_branch),
    .result_q    (result_q),
    .zero_q      (zero_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_comb();
    comb_exp_t e;
    tests_run++;
    assert (comb_q.size() > 0) else begin
      tests_failed++;
      $error("FAIL comb_queue observed=empty expected=entry");
    end
    if (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      chk({e.tag, ".strobes"}, {23'd0, alu_src, alu_op, mem_to_reg, reg_write,
                                mem_read, mem_write, branch, jump}, {23'd0, e.strobes});
      chk({e.tag, ".alu_control"}, {28'd0, alu_control}, {28'd0, e.ctrl});
      chk({e.tag, ".alu_result"}, alu_result, e.result);
      chk({e.tag, ".zero"}, {31'd0, zero}, {31'd0, e.zero});
      chk({e.tag, ".take_branch"}, {31'd0, take_branch}, {31'd0, e.take});
    end
  endtask

  task automatic step(input string tag, input logic [31:0] i, p, a, b, im,
                      input logic [8:0] s, input logic [3:0] c,
                      input logic [31:0] r, input logic z, input logic t);
    comb_exp_t e;
    @(negedge clk);
    instruction = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
    e.tag = tag; e.strobes = s; e.ctrl = c; e.result = r; e.zero = z; e.take = t;
    comb_q.push_back(e);
    #2;
    check_comb();
  endtask

  task automatic reg_step(input string tag, input logic [31:0] r, input logic z);
    reg_exp_t e;
    e.tag = tag; e.result = r; e.zero = z;
    reg_q.push_back(e);
    @(posedge clk);
    #1;
    tests_run++;
    assert (reg_q.size() > 0) else begin
      tests_failed++;
      $error("FAIL reg_queue observed=empty expected=entry");
    end
    if (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      chk({e.tag, ".result_q"}, result_q, e.result);
      chk({e.tag, ".zero_q"}, {31'd0, zero_q}, {31'd0, e.zero});
    end
  endtask

  initial begin
    rst = 1'b0;
    instruction = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;

    // Combinational outputs are live during reset; register stays cleared.
    step("add_in_reset", 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, S_R, 4'b0000, 32'd12, 1'b0, 1'b0);
    reg_step("rst_hold", 32'h0, 1'b0);
    rst = 1'b1;
    reg_step("rst_release", 32'd12, 1'b0);

    step("sub_zero", 32'h402081B3, 32'h0, 32'd7, 32'd7, 32'h0, S_R, 4'b0001, 32'h0, 1'b1, 1'b0);
    reg_step("sub_q", 32'h0, 1'b1);
    step("add_wrap", 32'h002081B3, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, S_R, 4'b0000, 32'h0, 1'b1, 1'b0);
    step("sll_shamt5", 32'h002091B3, 32'h0, 32'd3, 32'd33, 32'h0, S_R, 4'b0101, 32'd6, 1'b0, 1'b0);

    step("srai", 32'h4040D193, 32'h0, 32'h80000000, 32'h0, 32'd4, S_I, 4'b0111, 32'hF8000000, 1'b0, 1'b0);
    step("srli", 32'h0040D193, 32'h0, 32'h80000000, 32'h0, 32'd4, S_I, 4'b0110, 32'h08000000, 1'b0, 1'b0);
    step("addi_bit30", 32'h40008193, 32'h0, 32'd5, 32'd9, 32'h400, S_I, 4'b0000, 32'h405, 1'b0, 1'b0);
    step("sltu", 32'h0020B1B3, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, S_R, 4'b1001, 32'h0, 1'b1, 1'b0);
    step("slt", 32'h0020A1B3, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, S_R, 4'b1000, 32'h1, 1'b0, 1'b0);

    step("beq", 32'h00208063, 32'h0, 32'd9, 32'd9, 32'd8, S_BR, 4'b0001, 32'h0, 1'b1, 1'b1);
    step("bne", 32'h00209063, 32'h0, 32'd9, 32'd9, 32'd8, S_BR, 4'b0001, 32'h0, 1'b1, 1'b0);
    step("blt", 32'h0020C063, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h0, S_BR, 4'b1000, 32'h1, 1'b0, 1'b1);
    step("bge", 32'h0020D063, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, S_BR, 4'b1000, 32'h0, 1'b1, 1'b1);
    step("bgeu", 32'h0020F063, 32'h0, 32'd1, 32'hFFFFFFFF, 32'h0, S_BR, 4'b1001, 32'h1, 1'b0, 1'b0);

    step("lui", 32'h123451B7, 32'h100, 32'hDEADBEEF, 32'h0, 32'h12345000, S_U, 4'b0000, 32'h12345000, 1'b0, 1'b0);
    step("auipc", 32'h12345197, 32'h100, 32'hDEADBEEF, 32'h0, 32'h12345000, S_U, 4'b0000, 32'h12345100, 1'b0, 1'b0);
    step("lw", 32'h0080A183, 32'h0, 32'h100, 32'h55, 32'd8, S_LD, 4'b0000, 32'h108, 1'b0, 1'b0);
    step("sw", 32'h0020A423, 32'h0, 32'h100, 32'h55, 32'd8, S_ST, 4'b0000, 32'h108, 1'b0, 1'b0);
    step("jal", 32'h0000006F, 32'h0, 32'd2, 32'd3, 32'h0, S_JAL, 4'b0000, 32'd5, 1'b0, 1'b0);
    step("jalr", 32'h00008067, 32'h0, 32'h40, 32'd3, 32'd4, S_JALR, 4'b0000, 32'h44, 1'b0, 1'b0);
    step("illegal", 32'h0000007F, 32'h0, 32'd3, 32'd4, 32'd5, S_NONE, 4'b0000, 32'd7, 1'b0, 1'b0);

    // Reset asserted mid-stream, then released again.
    step("add_midstream", 32'h002081B3, 32'h0, 32'd5, 32'd7, 32'h0, S_R, 4'b0000, 32'd12, 1'b0, 1'b0);
    reg_step("run_q", 32'd12, 1'b0);
    rst = 1'b0;
    reg_step("rst_mid", 32'h0, 1'b0);
    rst = 1'b1;
    reg_step("rst_mid_release", 32'd12, 1'b0);

    tests_run++;
    assert (comb_q.size() == 0 && reg_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", comb_q.size() + reg_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/exec_decode_unit.md
Name: exec_decode_unit

Overview:
Combinational main-decoder, ALU-control decoder and 32-bit ALU for the single-cycle RV32I core, plus one registered copy of the ALU outputs for trace/pipeline use. It takes the fetched instruction, PC, register operands and the extended immediate. It produces datapath control strobes, the ALU result, the zero flag and the branch decision.

Parameters:
XLEN, 32, datapath width. Only 32 is supported.

Ports:
clk  in  1  core clock; the registered outputs update on the rising edge.
rst  in  1  synchronous reset, active-low.
instruction  in  32  current instruction.
pc  in  32  current PC, used as operand1 for AUIPC.
rs1_data  in  32  register-file read port 1.
rs2_data  in  32  register-file read port 2.
imm  in  32  sign-extended immediate from the immediate generator.
alu_src  out  1  selects operand2: 1 = imm, 0 = rs2_data.
alu_op  out  2  ALU operation class: 00 add, 01 branch, 10 R-type, 11 I-type ALU.
mem_to_reg  out  1  write-back data comes from memory.
reg_write  out  1  register-file write enable.
mem_read  out  1  memory read strobe.
mem_write  out  1  memory write strobe.
branch  out  1  conditional-branch instruction.
jump  out  1  JAL or JALR.
alu_control  out  4  decoded ALU operation.
alu_result  out  32  combinational ALU result.
zero  out  1  alu_result == 0.
take_branch  out  1  conditional branch is taken.
result_q  out  32  alu_result registered.
zero_q  out  1  zero registered.

Behaviour:
- Fields: opcode = instruction[6:0]; funct3 = instruction[14:12]; f7b5 = instruction[30].
- Main decode. Any flag not listed is 0.
  - 0110011 (R-type): reg_write, alu_op=10.
  - 0010011 (I-ALU): reg_write, alu_src, alu_op=11.
  - 0000011 (load): alu_src, mem_to_reg, reg_write, mem_read, alu_op=00.
  - 0100011 (store): alu_src, mem_write, alu_op=00.
  - 1100011 (branch): branch, alu_op=01.
  - 1101111 (JAL): jump, reg_write, alu_op=00.
  - 1100111 (JALR): jump, reg_write, alu_src, alu_op=00.
  - 0110111 (LUI) and 0010111 (AUIPC): reg_write, alu_src, alu_op=00.
  - Any other opcode: all strobes 0, alu_op=00.
- alu_control codes: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- ALU-control decode:
  - alu_op 00: ADD.
  - alu_op 01: funct3 000/001 → SUB; 100/101 → SLT; 110/111 → SLTU; 010/011 → SUB.
  - alu_op 10 or 11, by funct3: 000 ADD; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if f7b5=1; 110 OR; 111 AND.
  - Additionally, funct3 000 with f7b5=1 gives SUB only when alu_op=10. For I-type (alu_op=11), ADDI ignores f7b5.
- Operand1: pc for AUIPC, 32'h0 for LUI, otherwise rs1_data. Operand2: imm if alu_src, else rs2_data.
- ALU arithmetic:
  - Add and subtract wrap modulo 2^32.
  - Shift amount is operand2[4:0].
  - SRA replicates operand1[31].
  - SLT is a signed compare, SLTU unsigned; the result is 32'h1 or 32'h0.
  - Any undefined alu_control value yields 0.
- take_branch = branch and the condition selected by funct3:
  - 000: zero; 001: !zero.
  - 100: alu_result[0]; 101: !alu_result[0].
  - 110: alu_result[0]; 111: !alu_result[0].
  - 010/011: 0.
- All outputs except result_q and zero_q are purely combinational, with zero latency.
- Registered outputs:
  - On each rising clk with rst=0: result_q ← 0, zero_q ← 0.
  - Otherwise: result_q ← alu_result, zero_q ← zero.
  - Reset has no effect on the combinational outputs.

Decomposition:
- Shared package: opcode constants, alu_op encodings and the alu_control codes.
- The ALU is a natural sub-module, alu32_core (operand1, operand2, alu_control → result, zero).
- Main and ALU-control decode stay inline.

Test Plan:
- ADD/SUB R-type:
  - 0x002081B3 (add x3,x1,x2) with rs1=5, rs2=7 → alu_control=0000, alu_result=12, reg_write=1.
  - The same instruction with bit 30 set and rs1=rs2=7 → SUB, result 0, zero=1.
- Shifts and compares:
  - SRAI with imm=4 on rs1=0x80000000 → 0xF8000000.
  - SRLI with imm=4 on the same operand → 0x08000000.
  - SLTU 0xFFFFFFFF vs 1 → 0.
  - SLT 0xFFFFFFFF vs 1 → 1.
- Branches:
  - BEQ with rs1=rs2=9 → take_branch=1.
  - BNE with the same operands → 0.
  - BLT with rs1=-1, rs2=1 → 1.
  - BGEU with rs1=1, rs2=0xFFFFFFFF → 0.
- LUI/AUIPC/loads/stores:
  - LUI with imm=0x12345000 → result 0x12345000.
  - AUIPC with pc=0x100 and the same imm → 0x12345100.
  - LW → mem_read=1, mem_to_reg=1.
  - SW → mem_write=1, reg_write=0.
- Illegal opcode 0x0000007F → all strobes 0, alu_op=00.
- Reset and register:
  - Hold rst=0 across a clock edge → result_q=0, zero_q=0.
  - Release rst with add result 12 → result_q=12 after the next rising edge.
  - Assert rst mid-stream → result_q=0 at the following edge.
